// File: rtl/qam_pkg.sv
// Shared mode encoding and per-mode bit counts for the QAM hard-decision demapper.
package qam_pkg;

   typedef enum logic [1:0] {
      MODE_BPSK  = 2'd0,
      MODE_QPSK  = 2'd1,
      MODE_QAM16 = 2'd2,
      MODE_RSVD  = 2'd3
   } qam_mode_e;

   localparam logic [2:0] NBITS_BPSK  = 3'd1;
   localparam logic [2:0] NBITS_QPSK  = 3'd2;
   localparam logic [2:0] NBITS_QAM16 = 3'd4;

endpackage

// File: rtl/qam_demap_if.sv
// Symbol input and bit-group output handshake bundle of the QAM demapper.
interface qam_demap_if #(
   parameter int W     = 11,
   parameter int THR_W = W - 1
);
   logic                    valid_i;
   logic                    ready_i;
   logic signed [W-1:0]     ar;
   logic signed [W-1:0]     ai;
   logic [1:0]              mode;
   logic [THR_W-1:0]        thr;
   logic                    valid_x;
   logic                    ready_x;
   logic [3:0]              x;
   logic [2:0]              nbits;
   logic                    mode_err;

   modport master (
      output valid_i, ar, ai, mode, thr, ready_x,
      input  ready_i, valid_x, x, nbits, mode_err
   );

   modport slave (
      input  valid_i, ar, ai, mode, thr, ready_x,
      output ready_i, valid_x, x, nbits, mode_err
   );
endinterface

// File: rtl/qam_slicer_axis.sv
// Single-axis slicer: sign decision (zero counts as negative) and |v| > thr level decision.
module qam_slicer_axis #(
   parameter int W     = 11,
   parameter int THR_W = W - 1
) (
   input  logic signed [W-1:0] v,
   input  logic [THR_W-1:0]    thr,
   output logic                neg,
   output logic                lvl
);
   localparam int CW = (W > THR_W) ? W : THR_W;

   logic [W-1:0]  mag;
   logic [CW-1:0] mag_ext;
   logic [CW-1:0] thr_ext;

   // The most negative sample has no positive twin, so it clips to the largest magnitude.
   always_comb begin
      mag = $unsigned(v);
      if (v == {1'b1, {(W-1){1'b0}}}) begin
         mag = {1'b0, {(W-1){1'b1}}};
      end else if (v[W-1]) begin
         mag = $unsigned(-v);
      end
   end

   assign mag_ext = CW'(mag);
   assign thr_ext = CW'(thr);
   assign neg     = v[W-1] | (v == '0);
   assign lvl     = mag_ext > thr_ext;
endmodule

// File: rtl/qam_demap.sv
// Two-stage BPSK/QPSK/16-QAM hard-decision demapper with valid/ready backpressure.
// Optional symbol counter enabled by defining QAM_DEMAP_STATS_EN.
module qam_demap
   import qam_pkg::*;
#(
   parameter int W     = 11,
   parameter int THR_W = W - 1
) (
   input  logic        CLK,
   input  logic        RST,
   qam_demap_if.slave  bus
`ifdef QAM_DEMAP_STATS_EN
   ,
   input  logic        sym_clr,
   output logic [15:0] sym_cnt
`endif
);
   logic                s1_valid_reg;
   logic signed [W-1:0] s1_ar_reg;
   logic signed [W-1:0] s1_ai_reg;
   qam_mode_e           s1_mode_reg;
   logic [THR_W-1:0]    s1_thr_reg;

   logic                valid_x_reg;
   logic [3:0]          x_reg;
   logic [2:0]          nbits_reg;
   logic                mode_err_reg;

   logic                en;
   logic [3:0]          dec_x;
   logic [2:0]          dec_nbits;
   logic                dec_err;

   logic signed [W-1:0] axis_v   [2];
   logic                axis_neg [2];
   logic                axis_lvl [2];

   // Stage 1 may fill while stage 2 is stalled, giving one symbol of slack.
   assign en          = ~valid_x_reg | bus.ready_x;
   assign bus.ready_i = en | ~s1_valid_reg;

   assign axis_v[0] = s1_ar_reg;
   assign axis_v[1] = s1_ai_reg;

   for (genvar gi = 0; gi < 2; gi++) begin : g_axis
      qam_slicer_axis #(
         .W     (W),
         .THR_W (THR_W)
      ) u_slicer (
         .v   (axis_v[gi]),
         .thr (s1_thr_reg),
         .neg (axis_neg[gi]),
         .lvl (axis_lvl[gi])
      );
   end

   always_comb begin
      dec_x     = '0;
      dec_nbits = NBITS_QPSK;
      dec_err   = 1'b0;
      case (s1_mode_reg)
         MODE_BPSK: begin
            dec_x     = {3'b000, axis_neg[0]};
            dec_nbits = NBITS_BPSK;
         end
         MODE_QAM16: begin
            dec_x     = {axis_neg[1], axis_neg[0], axis_lvl[1], axis_lvl[0]};
            dec_nbits = NBITS_QAM16;
         end
         default: begin
            dec_x     = {2'b00, axis_neg[1], axis_neg[0]};
            dec_nbits = NBITS_QPSK;
            dec_err   = (s1_mode_reg == MODE_RSVD);
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         s1_valid_reg <= 1'b0;
         s1_ar_reg    <= '0;
         s1_ai_reg    <= '0;
         s1_mode_reg  <= MODE_BPSK;
         s1_thr_reg   <= '0;
      end else if (bus.ready_i) begin
         s1_valid_reg <= bus.valid_i;
         if (bus.valid_i) begin
            s1_ar_reg   <= bus.ar;
            s1_ai_reg   <= bus.ai;
            s1_mode_reg <= qam_mode_e'(bus.mode);
            s1_thr_reg  <= bus.thr;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         valid_x_reg  <= 1'b0;
         x_reg        <= '0;
         nbits_reg    <= '0;
         mode_err_reg <= 1'b0;
      end else if (en) begin
         valid_x_reg  <= s1_valid_reg;
         x_reg        <= s1_valid_reg ? dec_x : 4'd0;
         nbits_reg    <= s1_valid_reg ? dec_nbits : 3'd0;
         mode_err_reg <= s1_valid_reg & dec_err;
      end
   end

   assign bus.valid_x  = valid_x_reg;
   assign bus.x        = x_reg;
   assign bus.nbits    = nbits_reg;
   assign bus.mode_err = mode_err_reg;

`ifdef QAM_DEMAP_STATS_EN
   logic [15:0] sym_cnt_reg;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sym_cnt_reg <= '0;
      end else if (sym_clr) begin
         sym_cnt_reg <= '0;
      end else if (valid_x_reg && bus.ready_x && (sym_cnt_reg != 16'hFFFF)) begin
         sym_cnt_reg <= sym_cnt_reg + 16'd1;
      end
   end

   assign sym_cnt = sym_cnt_reg;
`endif
endmodule
